// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, FSM state encoding and the queued pixel request format.
package fb_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int COLOR_W   = 3;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] colour;
    } pixel_req_t;

    // Row-major linear address; widened before the multiply so nothing truncates.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel requests; combinational read of the head entry.
// Latency: push visible at the head one cycle later. Push ignored when full, pop ignored when empty.
// Backpressure: full is asserted at DEPTH entries; caller must gate pushes on it.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  pixel_req_t               din_i,
    output pixel_req_t               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    pixel_req_t          mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q;
    logic                do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// Queues draw/x/y pixels and writes them to the framebuffer, plus a full-screen clear; BOUNDS_CHECK_EN drops off-screen pixels.
// Latency: draw in cycle N on an empty queue -> write in cycle N+2; 1 pixel/cycle sustained.
// Backpressure: none upstream; draws while full are dropped (sticky overflow), draws during a clear queue up.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               draw_i,
    input  logic [X_W-1:0]     x_i,
    input  logic [Y_W-1:0]     y_i,
    input  logic [COLOR_W-1:0] color_i,
    input  logic               clear_req_i,
    input  logic [COLOR_W-1:0] clear_color_i,
    output logic               full_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic               oob_o,
    output logic               clear_done_o,
    output logic               wr_en_o,
    output logic [ADDR_W-1:0]  wr_addr_o,
    output logic [COLOR_W-1:0] wr_data_o
);
    state_t                      state_q;
    logic [ADDR_W-1:0]           cnt_q;
    logic [COLOR_W-1:0]          clr_color_q;
    logic                        wr_en_q, done_q, overflow_q;
    logic [ADDR_W-1:0]           wr_addr_q, pix_addr_d;
    logic [COLOR_W-1:0]          wr_data_q;

    pixel_req_t                  fifo_din, fifo_dout;
    logic                        in_range, push, pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef BOUNDS_CHECK_EN
    logic oob_q;
    assign in_range = (x_i < X_W'(FB_WIDTH)) && (y_i < Y_W'(FB_HEIGHT));

    always_ff @(posedge clk) begin
        if (reset)                     oob_q <= 1'b0;
        else if (draw_i && !in_range)  oob_q <= 1'b1;
    end
    assign oob_o = oob_q;
`else
    assign in_range = 1'b1;
    assign oob_o    = 1'b0;
`endif

    assign fifo_din   = '{x: x_i, y: y_i, colour: color_i};
    assign push       = draw_i && in_range && !fifo_full;
    // A cycle that accepts a clear never pops, so the queue is untouched until the clear ends.
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !clear_req_i;
    assign pix_addr_d = pix_addr(fifo_dout.x, fifo_dout.y);

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            clr_color_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (draw_i && in_range && fifo_full) overflow_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (clear_req_i) begin
                        state_q     <= S_CLEAR;
                        cnt_q       <= '0;
                        clr_color_q <= clear_color_i;
                    end else if (!fifo_empty) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= pix_addr_d;
                        wr_data_q <= fifo_dout.colour;
                    end
                end
                S_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= clr_color_q;
                    if (cnt_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign full_o       = fifo_full;
    assign busy_o       = (state_q == S_CLEAR) || (fifo_count != '0);
    assign overflow_o   = overflow_q;
    assign clear_done_o = done_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: queue-based reference model compared every cycle plus literal spot checks.
module tb_fb_pixel_writer;
    logic        clk = 1'b0;
    logic        reset, draw, clear_req;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color, clear_color;
    logic        full_o, busy_o, overflow_o, oob_o, clear_done_o, wr_en_o;
    logic [16:0] wr_addr_o;
    logic [2:0]  wr_data_o;

    int n_chk = 0;
    int n_fail = 0;

    fb_pixel_writer dut (
        .clk           (clk),
        .reset         (reset),
        .draw_i        (draw),
        .x_i           (x),
        .y_i           (y),
        .color_i       (color),
        .clear_req_i   (clear_req),
        .clear_color_i (clear_color),
        .full_o        (full_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o),
        .oob_o         (oob_o),
        .clear_done_o  (clear_done_o),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending pixels and a clear in progress, advanced once per clock edge.
    typedef struct {int x; int y; int c;} px_t;
    px_t mq[$];
    bit  m_clr = 0;
    int  m_cnt = 0, m_ccol = 0;
    bit  e_en = 0, e_done = 0, e_full = 0, e_busy = 0, e_ovf = 0, e_oob = 0;
    int  e_addr = 0, e_data = 0;

    always @(posedge clk) begin
        bit  full_b;
        px_t p;
        if (reset) begin
            mq.delete();
            m_clr = 0; m_cnt = 0;
            e_en = 0; e_done = 0; e_ovf = 0; e_oob = 0; e_addr = 0; e_data = 0;
        end else begin
            full_b = (mq.size() == 16);
            e_done = 0;
            if (m_clr) begin
                e_en = 1; e_addr = m_cnt; e_data = m_ccol;
                e_done = (m_cnt == 320*240 - 1);
                if (e_done) m_clr = 0; else m_cnt++;
            end else if (clear_req) begin
                e_en = 0; m_clr = 1; m_cnt = 0; m_ccol = int'(clear_color);
            end else if (mq.size() > 0) begin
                p = mq.pop_front();
                e_en = 1; e_addr = p.y * 320 + p.x; e_data = p.c;
            end else begin
                e_en = 0;
            end
            if (draw) begin
                p.x = int'(x); p.y = int'(y); p.c = int'(color);
`ifdef BOUNDS_CHECK_EN
                if (p.x >= 320 || p.y >= 240) e_oob = 1; else
`endif
                if (full_b) e_ovf = 1; else mq.push_back(p);
            end
        end
        e_full = (mq.size() == 16);
        e_busy = m_clr || (mq.size() > 0);
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if ({wr_en_o, clear_done_o, full_o, busy_o, overflow_o, oob_o} !==
                    {e_en, e_done, e_full, e_busy, e_ovf, e_oob} ||
                (e_en && (int'(wr_addr_o) != e_addr || int'(wr_data_o) != e_data))) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL model_cycle t=%0t got en=%b done=%b full=%b busy=%b ovf=%b oob=%b addr=%0d data=%0d want en=%b done=%b full=%b busy=%b ovf=%b oob=%b addr=%0d data=%0d",
                             $time, wr_en_o, clear_done_o, full_o, busy_o, overflow_o, oob_o, wr_addr_o, wr_data_o,
                             e_en, e_done, e_full, e_busy, e_ovf, e_oob, e_addr, e_data);
            end
        end
    end

    typedef struct packed {logic done; logic [2:0] data; logic [16:0] addr;} wr_t;
    wr_t wlog[$];
    bit  rec = 0, full_seen = 0;
    always @(negedge clk) begin
        if (rec) begin
            if (wr_en_o) wlog.push_back(wr_t'({clear_done_o, wr_data_o, wr_addr_o}));
            if (full_o) full_seen = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int xx, input int yy, input int cc);
        draw = 1'b1; x = 9'(xx); y = 8'(yy); color = 3'(cc);
        tick();
    endtask

    initial begin
        int k, bad, ndone, i;
        reset = 1'b1; draw = 1'b0; x = '0; y = '0; color = '0; clear_req = 1'b0; clear_color = '0;
        tick(); chk_en = 1; tick(); tick();
        check("reset_outputs", 32'({wr_en_o, clear_done_o, full_o, busy_o, overflow_o, oob_o, wr_addr_o, wr_data_o}), 0);
        reset = 1'b0; tick();

        put(10, 20, 5); draw = 1'b0;
        check("single_n1_en", wr_en_o, 0); tick();
        check("single_en", wr_en_o, 1);
        check("single_addr", wr_addr_o, 6410);
        check("single_data", wr_data_o, 5); tick();
        check("single_after_en", wr_en_o, 0);

        put(0, 0, 1); put(319, 239, 7); draw = 1'b0;
        check("corner0_en", wr_en_o, 1); check("corner0_addr", wr_addr_o, 0); check("corner0_data", wr_data_o, 1);
        tick();
        check("corner1_en", wr_en_o, 1); check("corner1_addr", wr_addr_o, 76799); check("corner1_data", wr_data_o, 7);
        tick(); check("corner_after_en", wr_en_o, 0);

        put(320, 5, 3); put(5, 240, 4); draw = 1'b0;
`ifdef BOUNDS_CHECK_EN
        check("oob_a_en", wr_en_o, 0); tick();
        check("oob_b_en", wr_en_o, 0);
        check("oob_flag", oob_o, 1);
`else
        check("oob_a_en", wr_en_o, 1); check("oob_a_addr", wr_addr_o, 1920); check("oob_a_data", wr_data_o, 3); tick();
        check("oob_b_addr", wr_addr_o, 76805); check("oob_b_data", wr_data_o, 4);
        check("oob_flag", oob_o, 0);
`endif
        check("oob_overflow", overflow_o, 0);
        tick(); tick();

        // Clear abandoned by reset once the counter reaches 1000, with three pixels queued.
        clear_color = 3'd6; clear_req = 1'b1; tick(); clear_req = 1'b0;
        put(1, 1, 1); put(2, 2, 2); put(3, 3, 3); draw = 1'b0;
        repeat (997) tick();
        check("midclear_addr", wr_addr_o, 999);
        check("midclear_data", wr_data_o, 6);
        check("midclear_busy", busy_o, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("post_reset_outputs", 32'({wr_en_o, busy_o, full_o, overflow_o, oob_o, clear_done_o}), 0);
        wlog.delete(); rec = 1; repeat (20) tick(); rec = 0;
        check("post_reset_writes", wlog.size(), 0);

        // Full clear with 20 draws arriving mid-clear.
        wlog.delete(); full_seen = 0; rec = 1;
        clear_color = 3'd2; clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (100) tick();
        for (int j = 0; j < 20; j++) put(j + 50, j, j % 8);
        draw = 1'b0;
        for (k = 0; k < 80000; k++) begin
            tick();
            if (!busy_o) break;
        end
        check("drain_in_time", 32'(k < 80000), 1);
        repeat (4) tick(); rec = 0;
        check("clear_drain_writes", wlog.size(), 76816);
        bad = 0; ndone = 0;
        for (int m = 0; m < wlog.size(); m++) begin
            if (wlog[m].done) ndone++;
            if (m < 76800) begin
                if (int'(wlog[m].addr) != m || wlog[m].data != 3'd2 || wlog[m].done != (m == 76799)) bad++;
            end else begin
                i = m - 76800;
                if (int'(wlog[m].addr) != i * 320 + i + 50 || int'(wlog[m].data) != i % 8 || wlog[m].done) bad++;
            end
        end
        check("clear_sequence_errors", bad, 0);
        check("clear_done_pulses", ndone, 1);
        if (wlog.size() == 76816) check("last_drain_addr", wlog[76815].addr, 4865);
        check("full_seen", full_seen, 1);
        check("overflow_set", overflow_o, 1);
        check("oob_end", oob_o, 0);
        check("busy_end", busy_o, 0);
        check("full_end", full_o, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
